pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into one per-stage stall vector. The ID request is the ID stage `stall_request` (load-related).
- Sequences exception/ERET flushes and supplies the redirect PC to IF.
- Runs a stall watchdog that flags a hung pipeline.

Parameters:
- ADDR_WIDTH, 32, width of PC/EPC/redirect address.
- EXC_VECTOR, 32'hBFC00380, redirect target for non-ERET exceptions.
- FLUSH_CYCLES, 1, cycles `flush` stays asserted per event (1..7).
- WATCHDOG_LIMIT, 1023, consecutive stall cycles before `stall_timeout` sets (1..65535).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall_request_if  input  1  IF waiting on instruction fetch
- stall_request_id  input  1  ID load-use stall request
- stall_request_ex  input  1  EX multi-cycle op busy
- stall_request_mem  input  1  MEM waiting on data access
- exc_valid  input  1  MEM-stage exception/ERET commit, 1-cycle pulse
- exc_eret  input  1  qualifies exc_valid: 1 = ERET
- cp0_epc  input  ADDR_WIDTH  EPC value from CP0
- stall  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0)
- flush  output  1  clears all pipeline registers
- redirect_pc  output  ADDR_WIDTH  new PC, valid while flush=1
- stall_timeout  output  1  sticky watchdog error
- ctrl_state  output  2  FSM state: 0 RUN, 1 FLUSH

Behaviour:
- Reset, asynchronous: stall=0, flush=0, redirect_pc=0, stall_timeout=0, ctrl_state=RUN, all counters=0.
- FSM states are RUN and FLUSH.
- RUN, stall is combinational from requests, highest stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- RUN with exc_valid=1:
  - stall forced to 0 in that cycle, regardless of requests.
  - At the next edge: redirect_pc ← (exc_eret ? cp0_epc : EXC_VECTOR), flush_cnt ← FLUSH_CYCLES, go to FLUSH.
- FLUSH:
  - flush=1 and stall=0 for exactly FLUSH_CYCLES cycles.
  - flush_cnt decrements each cycle; at 1, return to RUN next edge.
  - exc_valid is ignored; stall requests are ignored.
  - redirect_pc is held until the next exception.
- flush is registered: 1-cycle latency from exc_valid.
- Back-to-back: exc_valid in the first RUN cycle after FLUSH is accepted normally.
- Watchdog:
  - 16-bit wait_cnt increments each RUN cycle with stall≠0.
  - Clears on any cycle with stall=0, and in FLUSH.
  - Saturates at WATCHDOG_LIMIT.
  - When wait_cnt reaches WATCHDOG_LIMIT, stall_timeout ← 1 (sticky until rst).
- Reset mid-FLUSH: immediately returns to RUN, flush=0. A pending redirect is discarded.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_CNT_EN.
- Defined: adds two outputs.
  - perf_stall_cycles, 32 bits: counts RUN cycles with stall≠0; wraps at 2^32.
  - perf_flush_count, 32 bits: increments on each FLUSH entry; wraps.
  - Both reset to 0 on rst.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then stall_request_id=1 for 3 cycles → stall=6'b000111 exactly those 3 cycles, then 0; flush stays 0.
- stall_request_if and stall_request_mem together → stall=6'b011111; drop mem → 6'b000011 in the same cycle.
- exc_valid=1, exc_eret=0 with stall_request_ex=1 → stall=0 that cycle; next cycle flush=1, redirect_pc=32'hBFC00380, ctrl_state=1; RUN after 1 cycle.
- exc_valid=1, exc_eret=1, cp0_epc=32'h8000_0040, FLUSH_CYCLES=3 → flush high 3 cycles, redirect_pc=32'h8000_0040; exc_valid pulsed during FLUSH is ignored.
- WATCHDOG_LIMIT=8, hold stall_request_mem=1 → stall_timeout rises on the cycle wait_cnt reaches 8 (8th consecutive stall cycle) and stays 1 after the request drops, until rst.
- rst asserted asynchronously mid-FLUSH → flush=0, ctrl_state=0 without a clock edge. With PIPELINE_CTRL_PERF_CNT_EN defined, after 5 stall cycles and 2 exceptions: perf_stall_cycles=5, perf_flush_count=2.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake/bus bundle between the pipeline stages and the central sequencer.
// The pipeline side is the master; pipeline_ctrl is the slave.
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  stall_request_if;
    logic                  stall_request_id;
    logic                  stall_request_ex;
    logic                  stall_request_mem;
    logic                  exc_valid;
    logic                  exc_eret;
    logic [ADDR_WIDTH-1:0] cp0_epc;

    logic [5:0]            stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  stall_timeout;
    logic [1:0]            ctrl_state;

    modport master (
        output stall_request_if,
        output stall_request_id,
        output stall_request_ex,
        output stall_request_mem,
        output exc_valid,
        output exc_eret,
        output cp0_epc,
        input  stall,
        input  flush,
        input  redirect_pc,
        input  stall_timeout,
        input  ctrl_state
    );

    modport slave (
        input  stall_request_if,
        input  stall_request_id,
        input  stall_request_ex,
        input  stall_request_mem,
        input  exc_valid,
        input  exc_eret,
        input  cp0_epc,
        output stall,
        output flush,
        output redirect_pc,
        output stall_timeout,
        output ctrl_state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: stall merge, exception/ERET flush, stall watchdog.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR     = 32'hBFC00380,
    parameter int                    FLUSH_CYCLES   = 1,
    parameter int                    WATCHDOG_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    bus
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } state_e;

    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [15:0] WD_LIMIT   = 16'(WATCHDOG_LIMIT);

    state_e                state_q, state_d;
    logic [2:0]            flush_cnt_q, flush_cnt_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  stall_timeout_q, stall_timeout_d;

    logic [5:0]            stall_req;
    logic [5:0]            stall_run;
    logic                  flush_entry;

    // Highest stalled stage wins: it freezes itself and every stage upstream of it.
    always_comb begin
        stall_req = 6'b000000;
        if (bus.stall_request_mem) begin
            stall_req = 6'b011111;
        end else if (bus.stall_request_ex) begin
            stall_req = 6'b001111;
        end else if (bus.stall_request_id) begin
            stall_req = 6'b000111;
        end else if (bus.stall_request_if) begin
            stall_req = 6'b000011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= 3'd0;
            redirect_pc_q   <= '0;
            wait_cnt_q      <= 16'd0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            redirect_pc_q   <= redirect_pc_d;
            wait_cnt_q      <= wait_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        stall_run     = 6'b000000;
        flush_entry   = 1'b0;

        case (state_q)
            ST_RUN: begin
                // An exception commit overrides every stall so the flush starts cleanly.
                if (bus.exc_valid) begin
                    state_d       = ST_FLUSH;
                    flush_cnt_d   = FLUSH_INIT;
                    redirect_pc_d = bus.exc_eret ? bus.cp0_epc : EXC_VECTOR;
                    flush_entry   = 1'b1;
                end else begin
                    stall_run = stall_req;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // Watchdog: counts consecutive stalled RUN cycles, saturating at the limit.
    always_comb begin
        wait_cnt_d = 16'd0;
        if (stall_run != 6'b000000) begin
            wait_cnt_d = (wait_cnt_q >= WD_LIMIT) ? WD_LIMIT : (wait_cnt_q + 16'd1);
        end
        stall_timeout_d = stall_timeout_q | (wait_cnt_d == WD_LIMIT);
    end

    assign bus.stall         = rst ? 6'b000000 : stall_run;
    assign bus.flush         = (state_q == ST_FLUSH);
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.stall_timeout = stall_timeout_q;
    assign bus.ctrl_state    = state_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_run != 6'b000000) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (flush_entry) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    logic unused_flush_entry;
    assign unused_flush_entry = flush_entry;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances share stimulus, one with default
// flush length, one with FLUSH_CYCLES=3 and WATCHDOG_LIMIT=8.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic        exc_valid, exc_eret;
    logic [31:0] epc;

    int n_vec;
    int n_miss;

    pipeline_ctrl_if #(.ADDR_WIDTH(32)) bus_a ();
    pipeline_ctrl_if #(.ADDR_WIDTH(32)) bus_b ();

    assign bus_a.stall_request_if  = req_if;
    assign bus_a.stall_request_id  = req_id;
    assign bus_a.stall_request_ex  = req_ex;
    assign bus_a.stall_request_mem = req_mem;
    assign bus_a.exc_valid         = exc_valid;
    assign bus_a.exc_eret          = exc_eret;
    assign bus_a.cp0_epc           = epc;

    assign bus_b.stall_request_if  = req_if;
    assign bus_b.stall_request_id  = req_id;
    assign bus_b.stall_request_ex  = req_ex;
    assign bus_b.stall_request_mem = req_mem;
    assign bus_b.exc_valid         = exc_valid;
    assign bus_b.exc_eret          = exc_eret;
    assign bus_b.cp0_epc           = epc;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;
`endif

    pipeline_ctrl u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_a),
        .perf_flush_count  (perf_flush_a)
`endif
    );

    pipeline_ctrl #(
        .FLUSH_CYCLES   (3),
        .WATCHDOG_LIMIT (8)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_b),
        .perf_flush_count  (perf_flush_b)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        req_if    = 1'b0;
        req_id    = 1'b0;
        req_ex    = 1'b0;
        req_mem   = 1'b0;
        exc_valid = 1'b0;
        exc_eret  = 1'b0;
        epc       = 32'h0;

        // Reset values
        #2;
        check_vec("rst_stall",    64'(bus_a.stall), 64'h0);
        check_vec("rst_flush",    64'(bus_a.flush), 64'h0);
        check_vec("rst_redirect", 64'(bus_a.redirect_pc), 64'h0);
        check_vec("rst_timeout",  64'(bus_b.stall_timeout), 64'h0);
        check_vec("rst_state",    64'(bus_a.ctrl_state), 64'h0);
        #6;
        rst = 1'b0;
        tick();

        // ID load-use stall for exactly three cycles
        for (int i = 0; i < 3; i++) begin
            req_id = 1'b1;
            #1;
            check_vec("id_stall", 64'(bus_a.stall), 64'h07);
            check_vec("id_flush", 64'(bus_a.flush), 64'h0);
            tick();
        end
        req_id = 1'b0;
        #1;
        check_vec("id_release", 64'(bus_a.stall), 64'h0);
        tick();

        // Priority: MEM over IF, then IF alone in the same cycle
        req_if  = 1'b1;
        req_mem = 1'b1;
        #1;
        check_vec("mem_if_stall", 64'(bus_a.stall), 64'h1F);
        req_mem = 1'b0;
        #1;
        check_vec("if_stall", 64'(bus_a.stall), 64'h03);
        tick();
        req_if = 1'b0;
        #1;
        check_vec("if_release", 64'(bus_a.stall), 64'h0);
        tick();

        // Exception with EX busy: stall suppressed, one-cycle flush to the vector
        req_ex    = 1'b1;
        exc_valid = 1'b1;
        exc_eret  = 1'b0;
        #1;
        check_vec("exc_stall_zero", 64'(bus_a.stall), 64'h0);
        tick();
        exc_valid = 1'b0;
        check_vec("exc_flush",    64'(bus_a.flush), 64'h1);
        check_vec("exc_redirect", 64'(bus_a.redirect_pc), 64'hBFC00380);
        check_vec("exc_state",    64'(bus_a.ctrl_state), 64'h1);
        check_vec("exc_flush_stall", 64'(bus_a.stall), 64'h0);
        tick();
        check_vec("exc_back_run",  64'(bus_a.ctrl_state), 64'h0);
        check_vec("exc_flush_off", 64'(bus_a.flush), 64'h0);
        check_vec("exc_run_stall", 64'(bus_a.stall), 64'h0F);
        check_vec("exc_b_stall",   64'(bus_b.stall), 64'h0);
        req_ex = 1'b0;
        tick();
        check_vec("exc_b_flush3", 64'(bus_b.flush), 64'h1);
        tick();
        check_vec("exc_b_done",   64'(bus_b.flush), 64'h0);
        tick();

        // ERET with a three-cycle flush; a pulse during FLUSH is ignored by u_b
        exc_valid = 1'b1;
        exc_eret  = 1'b1;
        epc       = 32'h8000_0040;
        tick();
        exc_valid = 1'b0;
        check_vec("eret_flush1",    64'(bus_b.flush), 64'h1);
        check_vec("eret_redirect",  64'(bus_b.redirect_pc), 64'h80000040);
        check_vec("eret_state",     64'(bus_b.ctrl_state), 64'h1);
        tick();
        check_vec("eret_flush2",    64'(bus_b.flush), 64'h1);
        check_vec("eret_a_run",     64'(bus_a.flush), 64'h0);
        exc_valid = 1'b1;
        exc_eret  = 1'b0;
        tick();
        exc_valid = 1'b0;
        check_vec("eret_flush3",    64'(bus_b.flush), 64'h1);
        check_vec("eret_hold",      64'(bus_b.redirect_pc), 64'h80000040);
        check_vec("b2b_a_flush",    64'(bus_a.flush), 64'h1);
        check_vec("b2b_a_redirect", 64'(bus_a.redirect_pc), 64'hBFC00380);
        tick();
        check_vec("eret_end",       64'(bus_b.flush), 64'h0);
        check_vec("eret_end_state", 64'(bus_b.ctrl_state), 64'h0);
        check_vec("eret_end_pc",    64'(bus_b.redirect_pc), 64'h80000040);
        check_vec("b2b_a_end",      64'(bus_a.flush), 64'h0);
        tick();

        // Watchdog on u_b: sets on the eighth consecutive stall cycle, sticky
        req_mem = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_vec("wd_quiet", 64'(bus_b.stall_timeout), 64'h0);
        end
        tick();
        check_vec("wd_trip", 64'(bus_b.stall_timeout), 64'h1);
        req_mem = 1'b0;
        tick();
        check_vec("wd_sticky",   64'(bus_b.stall_timeout), 64'h1);
        check_vec("wd_a_quiet",  64'(bus_a.stall_timeout), 64'h0);
        tick();

        // Asynchronous reset in the middle of a flush
        exc_valid = 1'b1;
        exc_eret  = 1'b0;
        tick();
        exc_valid = 1'b0;
        check_vec("arst_pre_flush", 64'(bus_b.flush), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        check_vec("arst_flush",    64'(bus_b.flush), 64'h0);
        check_vec("arst_state",    64'(bus_b.ctrl_state), 64'h0);
        check_vec("arst_redirect", 64'(bus_b.redirect_pc), 64'h0);
        check_vec("arst_timeout",  64'(bus_b.stall_timeout), 64'h0);
        #2;
        rst = 1'b0;
        tick();
        check_vec("arst_after_state", 64'(bus_b.ctrl_state), 64'h0);
        check_vec("arst_after_flush", 64'(bus_b.flush), 64'h0);

`ifdef PIPELINE_CTRL_PERF_CNT_EN
        // Five stalled cycles and two exceptions since the last reset
        req_if = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        req_if = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exc_valid = 1'b1;
            tick();
            exc_valid = 1'b0;
            tick();
        end
        check_vec("perf_stall", 64'(perf_stall_a), 64'd5);
        check_vec("perf_flush", 64'(perf_flush_a), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
